// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N requesters share one FIFO write port, bursts of up to BURST_LEN words per grant.
// Define FIFO_WR_ARB_CNT_EN to add the wr_count output (running accepted-write count, PTR_WIDTH+1 bits).
module fifo_wr_arbiter #(
  parameter int PTR_WIDTH  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          wclk,
  input  logic                          wrstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack
`ifdef FIFO_WR_ARB_CNT_EN
  ,
  output logic [PTR_WIDTH:0]            wr_count
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BC_W  = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   next_ptr;
  logic               owner_req;
  logic               burst_last;

  // First set request bit at or above ptr, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && r[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign owner_req  = req[owner_q];
  assign burst_last = (burst_cnt_q == BC_W'(BURST_LEN - 1));
  assign wr_en      = (state_q == GRANT) & owner_req & ~full;
  assign wdata      = data_in[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  assign gnt        = gnt_q;
  assign next_ptr   = IDX_W'((int'(owner_q) + 1) % NUM_REQ);

  always_comb begin
    ack          = '0;
    ack[owner_q] = wr_en;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = GRANT;
          owner_d     = rr_pick(req, rr_ptr_q);
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        // full stalls the burst indefinitely; only a dropped req or a completed burst ends it.
        if (wr_en) burst_cnt_d = burst_cnt_q + BC_W'(1);
        if (!owner_req || (wr_en && burst_last)) begin
          rr_ptr_d    = next_ptr;
          burst_cnt_d = '0;
          if (|req) owner_d = rr_pick(req, next_ptr);
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d = '0;
    if (state_d == GRANT) gnt_d[owner_d] = 1'b1;
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      gnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_q       <= gnt_d;
    end
  end

`ifdef FIFO_WR_ARB_CNT_EN
  logic [PTR_WIDTH:0] wr_count_q, wr_count_d;

  // Wraps naturally, tracking the binary write pointer of the FIFO.
  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_en) wr_count_d = wr_count_q + (PTR_WIDTH+1)'(1);
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and scenario bench for fifo_wr_arbiter (NUM_REQ=4, BURST_LEN=4, DATA_WIDTH=8, PTR_WIDTH=3).
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int BL = 4;
  localparam int DW = 8;
  localparam int PW = 3;

  logic            wclk = 1'b0;
  logic            wrstn;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] data_in;
  logic            full;
  logic            wr_en;
  logic [DW-1:0]   wdata;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   ack;
`ifdef FIFO_WR_ARB_CNT_EN
  logic [PW:0]     wr_count;
`endif

  fifo_wr_arbiter #(
    .PTR_WIDTH (PW),
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .BURST_LEN (BL)
  ) dut (
    .wclk    (wclk),
    .wrstn   (wrstn),
    .req     (req),
    .data_in (data_in),
    .full    (full),
    .wr_en   (wr_en),
    .wdata   (wdata),
    .gnt     (gnt),
`ifdef FIFO_WR_ARB_CNT_EN
    .wr_count(wr_count),
`endif
    .ack     (ack)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: who holds the grant, how many words it has written, where the round-robin resumes.
  bit m_busy;
  int m_owner, m_rr, m_cnt, m_total;
  int obs_wr;
  int obs_ack[NR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r, input int from);
    for (int k = 0; k < NR; k++)
      if (r[(from + k) % NR]) return (from + k) % NR;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_total = 0;
    obs_wr = 0;
    for (int i = 0; i < NR; i++) obs_ack[i] = 0;
  endtask

  // Starts and ends 1 time unit after a rising edge; inputs are already applied.
  task automatic step();
    logic [NR-1:0] exp_gnt;
    bit            exp_wr;
    #4;
    exp_gnt = m_busy ? NR'(1 << m_owner) : '0;
    exp_wr  = m_busy && req[m_owner] && !full;
    check("gnt", gnt, exp_gnt);
    check("wr_en", wr_en, exp_wr);
    check("ack", ack, exp_wr ? exp_gnt : '0);
    if (exp_wr) check("wdata", wdata, data_in[m_owner*DW +: DW]);
`ifdef FIFO_WR_ARB_CNT_EN
    check("wr_count", wr_count, m_total % (1 << (PW + 1)));
`endif
    if (wr_en) obs_wr++;
    for (int i = 0; i < NR; i++) obs_ack[i] += ack[i];
    if (!m_busy) begin
      if (req != 0) begin
        m_busy = 1; m_owner = pick(req, m_rr); m_cnt = 0;
      end
    end else begin
      if (exp_wr) begin
        m_cnt++;
        m_total++;
      end
      if (!req[m_owner] || m_cnt == BL) begin
        m_rr  = (m_owner + 1) % NR;
        m_cnt = 0;
        if (req != 0) m_owner = pick(req, m_rr);
        else          m_busy  = 0;
      end
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic apply_reset();
    req = '0; full = 1'b0; wrstn = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_ack", ack, 0);
    model_reset();
    @(posedge wclk);
    @(posedge wclk);
    #1;
    wrstn = 1'b1;
  endtask

  initial begin
    wrstn = 1'b1; req = '0; full = 1'b0; data_in = '0;
    #2;

    // Scenario 1: lone requester 2 gets back-to-back bursts.
    apply_reset();
    data_in = $urandom; data_in[2*DW +: DW] = 8'hA5;
    req = 4'b0100;
    step();
    check("s1_gnt", gnt, 4'b0100);
    repeat (4) step();
    check("s1_writes", obs_wr, 4);
    check("s1_regrant", gnt, 4'b0100);
    step();

    // Scenario 2: all requesting, grants rotate 0,1,2,3,0 with no bubble.
    apply_reset();
    req = 4'b1111;
    step();
    for (int k = 0; k < 20; k++) begin
      data_in = $urandom;
      if (k % 4 == 0) check("s2_order", gnt, 32'(1 << ((k / 4) % NR)));
      step();
    end
    check("s2_writes", obs_wr, 20);

    // Scenario 3: full stalls requester 1 after two writes.
    apply_reset();
    req = 4'b1010;
    step();
    step();
    step();
    check("s3_pre_full", obs_wr, 2);
    full = 1'b1;
    repeat (5) step();
    check("s3_stalled", obs_wr, 2);
    full = 1'b0;
    step();
    step();
    check("s3_acks", obs_ack[1], 4);
    check("s3_next", gnt, 4'b1000);

    // Scenario 4: requester 0 drops after one write.
    apply_reset();
    req = 4'b1001;
    step();
    step();
    req = 4'b1000;
    step();
    check("s4_gnt", gnt, 4'b1000);
    check("s4_acks", obs_ack[0], 1);

    // Scenario 5: reset during requester 2's third write.
    apply_reset();
    req = 4'b0100;
    step();
    step();
    step();
    #4;
    check("s5_pre_wr", wr_en, 1);
    wrstn = 1'b0;
    #1;
    check("s5_gnt", gnt, 0);
    check("s5_wr_en", wr_en, 0);
    check("s5_ack", ack, 0);
    model_reset();
    @(posedge wclk);
    #1;
    wrstn = 1'b1;
    req = 4'b1111;
    step();
    check("s5_first", gnt, 4'b0001);

`ifdef FIFO_WR_ARB_CNT_EN
    // Scenario 6: 18 writes wrap a 4-bit counter to 2.
    apply_reset();
    req = 4'b1111;
    step();
    repeat (18) step();
    check("s6_wr_count", wr_count, 2);
`endif

    // Randomized traffic against the reference.
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) req[i] = ($urandom_range(0, 9) < 6);
      full    = ($urandom_range(0, 4) == 0);
      data_in = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter PTR_WIDTH, default 8, equal to the PTR_WIDTH of the downstream FIFO write pointer handler; it is used only for wr_count width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each requester's data word.
REQ-003 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..16).
REQ-004 The block SHALL have parameter BURST_LEN, default 4, giving the maximum accepted writes per grant (1..255).
REQ-005 Port: wclk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port: wrstn, input, 1, asynchronous active-low reset.
REQ-007 Port: req, input, NUM_REQ, per-requester write request, level-sensitive.
REQ-008 Port: data_in, input, NUM_REQ*DATA_WIDTH, requester i's word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port: full, input, 1, registered FIFO full flag from the write pointer handler.
REQ-010 Port: wr_en, output, 1, FIFO write enable.
REQ-011 Port: wdata, output, DATA_WIDTH, FIFO write data.
REQ-012 Port: gnt, output, NUM_REQ, registered one-hot grant; all zero when idle.
REQ-013 Port: ack, output, NUM_REQ, one-hot pulse marking that requester's word was accepted this cycle.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT; owner index, rr_ptr and burst_cnt SHALL be registers.
REQ-015 In IDLE with req nonzero, the next state SHALL be GRANT, with owner = first set req bit searching upward, with wrap, from rr_ptr.
REQ-016 Grant latency SHALL be exactly one cycle: req rising at edge N gives gnt valid after edge N+1.
REQ-017 wr_en SHALL be combinational: (state==GRANT) & req[owner] & !full.
REQ-018 wdata SHALL equal data_in slice [owner]; its value is don't-care when wr_en=0.
REQ-019 ack[owner] SHALL equal wr_en; all other ack bits SHALL be 0.
REQ-020 Each cycle with wr_en=1, burst_cnt SHALL increment by 1; full=1 SHALL freeze burst_cnt and hold the grant with no timeout.
REQ-021 The grant SHALL end at an edge when either req[owner]=0, or wr_en=1 and burst_cnt==BURST_LEN-1.
REQ-022 On grant end, rr_ptr SHALL become (owner+1) mod NUM_REQ and burst_cnt SHALL become 0.
REQ-023 On grant end, if any req bit is set, the FSM SHALL go directly GRANT->GRANT using the new rr_ptr; the old owner has lowest priority, and there is no idle bubble.
REQ-024 On grant end with no req bits set, the FSM SHALL go to IDLE and gnt SHALL be 0.
REQ-025 A requester dropping req while full=1 SHALL lose the grant with no write performed.

Reset
REQ-026 While wrstn=0, state SHALL be IDLE; gnt, owner, rr_ptr and burst_cnt SHALL be 0; wr_en and ack SHALL be 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately; after release, arbitration SHALL restart from requester 0.

Configuration
REQ-028 With macro FIFO_WR_ARB_CNT_EN defined, the block SHALL add output port wr_count, width PTR_WIDTH+1, reset to 0, incremented by 1 per wr_en=1 cycle, wrapping modulo 2^(PTR_WIDTH+1) to match the binary write pointer.
REQ-029 Without FIFO_WR_ARB_CNT_EN, the wr_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (NUM_REQ=4, BURST_LEN=4, DATA_WIDTH=8)
REQ-030 Scenario 1: only req[2]=1 held, data_in[2]=0xA5, full=0 -> gnt=4'b0100 one cycle later; four wr_en pulses with wdata=0xA5; then a regrant to requester 2 with no gap.
REQ-031 Scenario 2: req=4'b1111 held, full=0 -> grants 0,1,2,3,0 in order, four writes each, wr_en continuously 1.
REQ-032 Scenario 3: requester 1 granted, full=1 for 5 cycles after its 2nd write -> wr_en=0 and burst_cnt frozen at 2; after full=0, exactly 2 more writes, then the grant moves on.
REQ-033 Scenario 4: req[0] dropped after 1 write while req[3]=1 -> the next cycle gnt=4'b1000, and requester 0 got only 1 ack.
REQ-034 Scenario 5: wrstn pulsed low during requester 2's 3rd write -> gnt=0 and wr_en=0 immediately; after release with req=4'b1111, requester 0 is granted first.
REQ-035 Scenario 6 (FIFO_WR_ARB_CNT_EN defined, PTR_WIDTH=3): 18 accepted writes -> wr_count=2, after wrapping at 16.
